// File: rtl/tap_pkg.sv
// Shared definitions for the boundary-scan TAP controller: the 16 TAP states,
// instruction opcodes and the fixed Capture-IR pattern.
package tap_pkg;

    typedef enum logic [3:0] {
        ST_TLR,
        ST_RTI,
        ST_SEL_DR,
        ST_CAP_DR,
        ST_SHIFT_DR,
        ST_EXIT1_DR,
        ST_PAUSE_DR,
        ST_EXIT2_DR,
        ST_UPD_DR,
        ST_SEL_IR,
        ST_CAP_IR,
        ST_SHIFT_IR,
        ST_EXIT1_IR,
        ST_PAUSE_IR,
        ST_EXIT2_IR,
        ST_UPD_IR
    } tap_state_e;

    // Opcodes narrower than the IR; BYPASS is all-ones at whatever width the IR is.
    localparam int unsigned OPC_EXTEST         = 0;
    localparam int unsigned OPC_SAMPLE_PRELOAD = 1;
    localparam int unsigned OPC_IDCODE         = 2;

    // Capture-IR loads {0.., 0, 1}; the two LSBs are the fixed marker bits.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller state machine, advanced on TCK rising by TMS.
// Produces one-hot decodes of the states that the data/instruction paths act on.
//
//  state     | meaning
//  ----------+-------------------------------------------
//  TLR       | test-logic-reset, test logic idle/reset
//  RTI       | run-test/idle
//  SEL_DR    | select DR scan (branch point)
//  CAP_DR    | leaving edge captures the selected DR
//  SHIFT_DR  | leaving edge shifts the selected DR
//  EXIT1_DR  | branch to pause or update
//  PAUSE_DR  | DR holds, no strobes
//  EXIT2_DR  | branch back to shift or update
//  UPD_DR    | leaving edge latches DR into outputs
//  SEL_IR..  | same meaning for the instruction path
module tap_fsm
    import tap_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tms_i,
    output logic tlr_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o
);

    tap_state_e r_state;
    tap_state_e w_next;

    // State register; TRST forces Test-Logic-Reset immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_TLR;
        else         r_state <= w_next;
    end

    // Next-state per TMS and the state decodes.
    always_comb begin
        w_next       = r_state;
        tlr_o        = 1'b0;
        capture_dr_o = 1'b0;
        shift_dr_o   = 1'b0;
        update_dr_o  = 1'b0;
        capture_ir_o = 1'b0;
        shift_ir_o   = 1'b0;
        update_ir_o  = 1'b0;
        case (r_state)
            ST_TLR:      begin w_next = tms_i ? ST_TLR      : ST_RTI;      tlr_o = 1'b1;        end
            ST_RTI:            w_next = tms_i ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:         w_next = tms_i ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   begin w_next = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR; capture_dr_o = 1'b1; end
            ST_SHIFT_DR: begin w_next = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR; shift_dr_o = 1'b1;   end
            ST_EXIT1_DR:       w_next = tms_i ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR:       w_next = tms_i ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR:       w_next = tms_i ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   begin w_next = tms_i ? ST_SEL_DR   : ST_RTI;      update_dr_o = 1'b1;  end
            ST_SEL_IR:         w_next = tms_i ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   begin w_next = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR; capture_ir_o = 1'b1; end
            ST_SHIFT_IR: begin w_next = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR; shift_ir_o = 1'b1;   end
            ST_EXIT1_IR:       w_next = tms_i ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR:       w_next = tms_i ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR:       w_next = tms_i ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   begin w_next = tms_i ? ST_SEL_DR   : ST_RTI;      update_ir_o = 1'b1;  end
            default:           w_next = ST_TLR;
        endcase
    end

endmodule

// File: rtl/bscan_tap_ctrl.sv
// JTAG TAP controller for the boundary-scan chain: instruction register,
// IDCODE/BYPASS data registers, chain strobes and the falling-edge TDO stage.
module bscan_tap_ctrl
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0DB3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic                bs_shift_dr_o,
    output logic                bs_capture_dr_o,
    output logic                bs_update_dr_o,
    output logic                bs_enable_o,
    output logic                bs_mode_o,
    output logic                bs_scan_in_o,
    input  logic                bs_scan_out_i,
    output logic [IR_WIDTH-1:0] ir_o
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OPC_SAMPLE_PRELOAD);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);

    logic w_tlr, w_cap_dr, w_shift_dr, w_upd_dr, w_cap_ir, w_shift_ir, w_upd_ir;
    logic [IR_WIDTH-1:0] r_ir, r_ir_sr, w_ir;
    logic [31:0] r_idcode_sr;
    logic r_bypass;
    logic r_tdo, r_tdo_oe;
    logic w_sel_chain, w_sel_idcode, w_dr_tdo;

    tap_fsm u_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tms_i        (tms_i),
        .tlr_o        (w_tlr),
        .capture_dr_o (w_cap_dr),
        .shift_dr_o   (w_shift_dr),
        .update_dr_o  (w_upd_dr),
        .capture_ir_o (w_cap_ir),
        .shift_ir_o   (w_shift_ir),
        .update_ir_o  (w_upd_ir)
    );

    // Reading IDCODE while in TLR makes the reset instruction visible the moment
    // TLR is entered, not one TCK later.
    assign w_ir         = w_tlr ? IR_IDCODE : r_ir;
    assign w_sel_chain  = (w_ir == IR_EXTEST) || (w_ir == IR_SAMPLE);
    assign w_sel_idcode = (w_ir == IR_IDCODE);

    assign ir_o            = w_ir;
    assign bs_enable_o     = w_sel_chain;
    assign bs_mode_o       = (w_ir == IR_EXTEST);
    assign bs_capture_dr_o = w_cap_dr   & w_sel_chain;
    assign bs_shift_dr_o   = w_shift_dr & w_sel_chain;
    assign bs_update_dr_o  = w_upd_dr   & w_sel_chain;
    assign bs_scan_in_o    = tdi_i;

    // Instruction shift register and instruction latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ir    <= IR_IDCODE;
            r_ir_sr <= '0;
        end else if (w_tlr) begin
            r_ir    <= IR_IDCODE;
            r_ir_sr <= '0;
        end else begin
            if (w_cap_ir)        r_ir_sr <= IR_CAPTURE;
            else if (w_shift_ir) r_ir_sr <= {tdi_i, r_ir_sr[IR_WIDTH-1:1]};
            if (w_upd_ir)        r_ir    <= r_ir_sr;
        end
    end

    // IDCODE and BYPASS data registers; both track Shift-DR, TDO picks one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idcode_sr <= '0;
            r_bypass    <= 1'b0;
        end else if (w_tlr) begin
            r_bypass    <= 1'b0;
        end else if (w_cap_dr) begin
            r_idcode_sr <= IDCODE_VALUE;
            r_bypass    <= 1'b0;
        end else if (w_shift_dr) begin
            r_idcode_sr <= {tdi_i, r_idcode_sr[31:1]};
            r_bypass    <= tdi_i;
        end
    end

    assign w_dr_tdo = w_sel_chain  ? bs_scan_out_i :
                      w_sel_idcode ? r_idcode_sr[0] : r_bypass;

    // TDO launched on TCK falling so the far end samples it on the next rising edge.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else if (w_tlr) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else if (w_shift_ir) begin
            r_tdo    <= r_ir_sr[0];
            r_tdo_oe <= 1'b1;
        end else if (w_shift_dr) begin
            r_tdo    <= w_dr_tdo;
            r_tdo_oe <= 1'b1;
        end else begin
            r_tdo_oe <= 1'b0;
        end
    end

    assign tdo_o    = r_tdo;
    assign tdo_oe_o = r_tdo_oe;

endmodule
